// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - cache/memory side bundle for the shared-memory arbiter
//
// Purpose: groups the cache request/done handshakes, the main-memory bus and
// the cache fill port into one bundle.
//
// Modports:
//   slave  - the arbiter: takes cache requests and read data, drives the
//            memory bus, the fill port and the done pulses.
//   master - the caches plus main memory: the mirror image of slave.
//
// Signals:
//   i_req/i_addr             I-cache miss request (level) and byte address
//   d_req/d_addr             D-cache miss request (level) and byte address
//   d_wr_req/d_wr_data       D-cache write-through store (level) and data
//   mem_enable/mem_wr        memory access enable / write strobe
//   mem_addr/mem_data_in     memory byte address / write data
//   mem_data_out             memory read data
//   mem_data_valid           read data valid, fixed latency after issue
//   fill_we/sel/idx/data     returned word steered to the missing cache
//   i_done/d_done/d_wr_done  one-cycle completion pulses
//   busy                     arbiter not idle

interface mem_arbiter_if #(
   parameter int WORDS_PER_BLOCK = 8,
   parameter int IDX_W           = 3
);
   logic              i_req;
   logic [15:0]       i_addr;
   logic              d_req;
   logic [15:0]       d_addr;
   logic              d_wr_req;
   logic [15:0]       d_wr_data;
   logic              mem_enable;
   logic              mem_wr;
   logic [15:0]       mem_addr;
   logic [15:0]       mem_data_in;
   logic [15:0]       mem_data_out;
   logic              mem_data_valid;
   logic              fill_we;
   logic              fill_sel;
   logic [IDX_W-1:0]  fill_idx;
   logic [15:0]       fill_data;
   logic              i_done;
   logic              d_done;
   logic              d_wr_done;
   logic              busy;

   modport slave (
      input  i_req, i_addr, d_req, d_addr, d_wr_req, d_wr_data,
      input  mem_data_out, mem_data_valid,
      output mem_enable, mem_wr, mem_addr, mem_data_in,
      output fill_we, fill_sel, fill_idx, fill_data,
      output i_done, d_done, d_wr_done, busy
   );

   modport master (
      output i_req, i_addr, d_req, d_addr, d_wr_req, d_wr_data,
      output mem_data_out, mem_data_valid,
      input  mem_enable, mem_wr, mem_addr, mem_data_in,
      input  fill_we, fill_sel, fill_idx, fill_data,
      input  i_done, d_done, d_wr_done, busy
   );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - sequences I-fill, D-fill and D-store traffic onto one memory
//
// Purpose: owns the single multi-cycle main memory. Write-through stores go
// out in one cycle; block fills issue WORDS_PER_BLOCK pipelined reads
// back-to-back and steer each returned word to the cache that missed.
// Priority at grant: store > D-fill > I-fill.
//
// Ports:
//   clk  - system clock
//   rst  - synchronous, active-high reset
//   bus  - mem_arbiter_if.slave: cache handshakes, memory bus, fill port

module mem_arbiter #(
   parameter int WORDS_PER_BLOCK = 8,
   parameter int IDX_W           = 3
) (
   input  logic           clk,
   input  logic           rst,
   mem_arbiter_if.slave   bus
);

   // One extra bit on the issue counter so "all words issued" is its MSB.
   localparam int               CNT_W    = IDX_W + 1;
   // Block size in bytes minus one: clears the in-block offset of an address.
   localparam logic [15:0]      BLK_MASK = 16'(2 * WORDS_PER_BLOCK - 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_BLOCK - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WRITE,
      S_FILL,
      S_DONE
   } state_t;

   state_t             state_q, state_d;
   logic               owner_q, owner_d;     // 0 = I-cache, 1 = D-cache
   logic [15:0]        base_q,  base_d;
   logic [CNT_W-1:0]   iss_q,   iss_d;
   logic [IDX_W-1:0]   rcv_q,   rcv_d;

   logic               issuing;
   logic [15:0]        iss_off;

   logic               mem_enable_c;
   logic               mem_wr_c;
   logic [15:0]        mem_addr_c;
   logic [15:0]        mem_data_in_c;
   logic               fill_we_c;
   logic               fill_sel_c;
   logic [IDX_W-1:0]   fill_idx_c;
   logic [15:0]        fill_data_c;
   logic               i_done_c;
   logic               d_done_c;
   logic               d_wr_done_c;

   assign issuing = ~iss_q[IDX_W];
   // Word index to byte offset; block alignment of base means no carry out.
   assign iss_off = 16'({iss_q[IDX_W-1:0], 1'b0});

   always_comb begin
      state_d       = state_q;
      owner_d       = owner_q;
      base_d        = base_q;
      iss_d         = iss_q;
      rcv_d         = rcv_q;
      mem_enable_c  = 1'b0;
      mem_wr_c      = 1'b0;
      mem_addr_c    = 16'h0000;
      mem_data_in_c = 16'h0000;
      fill_we_c     = 1'b0;
      fill_sel_c    = 1'b0;
      fill_idx_c    = '0;
      fill_data_c   = 16'h0000;
      i_done_c      = 1'b0;
      d_done_c      = 1'b0;
      d_wr_done_c   = 1'b0;

      case (state_q)
         S_IDLE: begin
            // Read returns seen here are leftovers from an aborted fill.
            if (bus.d_wr_req) begin
               state_d = S_WRITE;
            end else if (bus.d_req) begin
               state_d = S_FILL;
               owner_d = 1'b1;
               base_d  = bus.d_addr & ~BLK_MASK;
               iss_d   = '0;
               rcv_d   = '0;
            end else if (bus.i_req) begin
               state_d = S_FILL;
               owner_d = 1'b0;
               base_d  = bus.i_addr & ~BLK_MASK;
               iss_d   = '0;
               rcv_d   = '0;
            end
         end

         S_WRITE: begin
            mem_enable_c  = 1'b1;
            mem_wr_c      = 1'b1;
            mem_addr_c    = bus.d_addr;
            mem_data_in_c = bus.d_wr_data;
            d_wr_done_c   = 1'b1;
            state_d       = S_IDLE;
         end

         S_FILL: begin
            if (issuing) begin
               mem_enable_c = 1'b1;
               mem_addr_c   = base_q + iss_off;
               iss_d        = iss_q + 1'b1;
            end
            // Returns may overlap the tail of the issue phase.
            if (bus.mem_data_valid) begin
               fill_we_c   = 1'b1;
               fill_sel_c  = owner_q;
               fill_idx_c  = rcv_q;
               fill_data_c = bus.mem_data_out;
               rcv_d       = rcv_q + 1'b1;
               if (rcv_q == LAST_IDX) begin
                  state_d = S_DONE;
               end
            end
         end

         S_DONE: begin
            // Request is still high here; going to IDLE (not re-arbitrating)
            // gives the cache one cycle to drop it after the pulse.
            i_done_c = ~owner_q;
            d_done_c = owner_q;
            state_d  = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         owner_q <= 1'b0;
         base_q  <= 16'h0000;
         iss_q   <= '0;
         rcv_q   <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         base_q  <= base_d;
         iss_q   <= iss_d;
         rcv_q   <= rcv_d;
      end
   end

   assign bus.mem_enable  = mem_enable_c;
   assign bus.mem_wr      = mem_wr_c;
   assign bus.mem_addr    = mem_addr_c;
   assign bus.mem_data_in = mem_data_in_c;
   assign bus.fill_we     = fill_we_c;
   assign bus.fill_sel    = fill_sel_c;
   assign bus.fill_idx    = fill_idx_c;
   assign bus.fill_data   = fill_data_c;
   assign bus.i_done      = i_done_c;
   assign bus.d_done      = d_done_c;
   assign bus.d_wr_done   = d_wr_done_c;
   assign bus.busy        = (state_q != S_IDLE);

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequences the single shared multi-cycle main memory between I-cache miss fills, D-cache miss fills and D-cache write-through stores.
- Sits between both caches and the main memory in the pipelined CPU; the caches stall the pipeline while their request is outstanding.
- Fills are block-sized and issue pipelined reads back-to-back; returned words are steered to the cache that missed.

Parameters:
- WORDS_PER_BLOCK, 8, 16-bit words per cache block; power of two, at least 2.
- IDX_W, 3, width of the word index; equals log2(WORDS_PER_BLOCK).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- i_req  input  1  I-cache miss request; level, held until i_done
- i_addr  input  16  I-cache miss byte address
- d_req  input  1  D-cache miss request; level, held until d_done
- d_addr  input  16  D-cache miss or store byte address
- d_wr_req  input  1  D-cache write-through store; level, held until d_wr_done
- d_wr_data  input  16  store data
- mem_enable  output  1  memory access enable
- mem_wr  output  1  memory write strobe
- mem_addr  output  16  memory byte address
- mem_data_in  output  16  memory write data
- mem_data_out  input  16  memory read data
- mem_data_valid  input  1  read data valid, fixed latency after the issuing cycle
- fill_we  output  1  write the returned word into the target cache
- fill_sel  output  1  fill target: 0 = I-cache, 1 = D-cache
- fill_idx  output  IDX_W  word index within the block
- fill_data  output  16  returned word
- i_done  output  1  one-cycle pulse: I fill complete
- d_done  output  1  one-cycle pulse: D fill complete
- d_wr_done  output  1  one-cycle pulse: store accepted
- busy  output  1  high in any state other than IDLE

Behaviour:
- Clock and reset: single clock, clk. Reset rst is synchronous and active-high. On rst the FSM goes to IDLE, all counters clear to 0, and every output is 0.
- States: IDLE, WRITE, FILL, DONE.
- IDLE, priority d_wr_req > d_req > i_req:
  - d_wr_req -> WRITE.
  - d_req -> FILL with owner = D, base = d_addr with the low log2(2*WORDS_PER_BLOCK) bits cleared.
  - i_req -> FILL with owner = I, base computed the same way from i_addr.
  - The owner and base are latched at grant. Requests that are not granted stay pending; there is no combinational grant.
  - mem_data_valid is ignored in IDLE, which drops stale returns after a reset.
- WRITE (exactly 1 cycle):
  - mem_enable = 1, mem_wr = 1, mem_addr = d_addr, mem_data_in = d_wr_data.
  - d_wr_done = 1 in this cycle; next state is IDLE.
- FILL:
  - Issue counter iss runs 0..WORDS_PER_BLOCK-1. While iss < WORDS_PER_BLOCK: mem_enable = 1, mem_wr = 0, mem_addr = base + 2*iss; iss increments every cycle.
  - Receive counter rcv counts mem_data_valid beats. Each beat drives fill_we = 1, fill_sel = owner, fill_idx = rcv, fill_data = mem_data_out combinationally in the same cycle.
  - When the beat with rcv = WORDS_PER_BLOCK-1 arrives, next state is DONE.
  - Issue and receive may overlap.
  - Owner, base and requests are not re-sampled during FILL. Deasserting a request mid-fill does not abort the fill.
- DONE (1 cycle):
  - i_done or d_done pulses according to owner; next state is IDLE.
  - The request is still high in this cycle and must not re-grant; the cache drops it on the done pulse.
  - Re-arbitration happens in the following IDLE cycle.
- Latency:
  - Store: grant cycle plus 1 cycle.
  - Fill: grant, then WORDS_PER_BLOCK issue cycles, then the memory latency, then 1 DONE cycle. With 8 words and 4-cycle memory, done arrives 12 cycles after FILL entry.
- Outputs not named in a state are 0.
- Address arithmetic is 16-bit and wraps modulo 2^16. Block alignment guarantees no carry out of the block.
- A reset during FILL returns to IDLE, and any memory returns still in flight are discarded.

Test Plan:
- Reset while FILL is active -> next cycle all outputs 0, busy = 0. The 3 remaining valids arrive in IDLE and produce no fill_we.
- i_req = 1 with i_addr = 0x1236 -> mem_addr issues 0x1230, 0x1232 … 0x123E on 8 consecutive cycles. 8 fill_we beats follow with fill_sel = 0 and fill_idx 0..7 carrying mem data. i_done pulses exactly once.
- d_req, i_req and d_wr_req all rise in the same cycle (d_addr = 0x0040, data 0xBEEF) -> the WRITE cycle comes first: mem_wr = 1, addr 0x0040, data 0xBEEF, d_wr_done pulses. Then the D fill runs from base 0x0040 with fill_sel = 1, then the I fill.
- i_req drops mid-fill -> the fill still completes all 8 beats and i_done pulses.
- i_req held through DONE -> exactly one i_done pulse, with no second grant before IDLE. A held d_wr_req is granted in that IDLE cycle.
- Address 0xFFFE fill -> base 0xFFF0, last issue 0xFFFE, no wrap beyond the block.
